// File: rtl/reg_dump_tx.sv
// reg_dump_tx: snapshots the register file's flat debug bus on request and
// streams it to the UART transmitter as a framed byte sequence:
//   header byte, every register MSB byte first (reg 0 first), XOR checksum.
// The checksum covers the data bytes only; the header is not included.
module reg_dump_tx #(
    parameter int          PROC_BITS   = 32,
    parameter int          REG_COUNT   = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                           clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [PROC_BITS*REG_COUNT-1:0] i_debug_regs,
    input  logic                           i_tx_ready,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_valid,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int BUS_W         = PROC_BITS * REG_COUNT;
    localparam int BYTES_PER_REG = PROC_BITS / 8;
    localparam int NUM_BYTES     = BYTES_PER_REG * REG_COUNT;
    localparam int IDX_W         = $clog2(NUM_BYTES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE
    } state_t;

    state_t             state_q;
    logic [BUS_W-1:0]   snapshot_q;
    logic [IDX_W-1:0]   byteIdx_q;
    logic [IDX_W-1:0]   byteIdx_d;
    logic [7:0]         checksum_q;
    logic [7:0]         checksum_d;
    logic [7:0]         nextByte;
    logic               transfer;

    // Frame byte k lives in register k/BYTES_PER_REG; within a register the
    // most significant byte goes out first.
    function automatic logic [7:0] byteAt(input logic [BUS_W-1:0] snap,
                                          input logic [IDX_W-1:0] k);
        int               idx;
        int               offset;
        logic [BUS_W-1:0] shifted;
        idx     = int'(k);
        offset  = (idx / BYTES_PER_REG) * PROC_BITS
                + (BYTES_PER_REG - 1 - (idx % BYTES_PER_REG)) * 8;
        shifted = snap >> offset;
        return shifted[7:0];
    endfunction

    assign transfer = o_tx_valid & i_tx_ready;

    // Look-ahead for the byte that follows an accepted transfer, so the
    // registered output can be updated in the same edge as the handshake.
    always_comb begin
        byteIdx_d  = byteIdx_q + 1'b1;
        if (state_q == HEADER) begin
            byteIdx_d = '0;
        end
        nextByte   = byteAt(snapshot_q, byteIdx_d);
        checksum_d = checksum_q ^ o_tx_data;
    end

    // Snapshot of the debug bus, taken only when a frame is accepted in IDLE;
    // it has no reset because its contents are irrelevant until captured.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && i_start) begin
            snapshot_q <= i_debug_regs;
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            byteIdx_q  <= '0;
            checksum_q <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state_q    <= HEADER;
                        byteIdx_q  <= '0;
                        checksum_q <= '0;
                        o_tx_data  <= HEADER_BYTE;
                        o_tx_valid <= 1'b1;
                        o_busy     <= 1'b1;
                    end
                end
                HEADER: begin
                    if (transfer) begin
                        state_q   <= DATA;
                        byteIdx_q <= '0;
                        o_tx_data <= nextByte;
                    end
                end
                DATA: begin
                    if (transfer) begin
                        checksum_q <= checksum_d;
                        if (byteIdx_q == LAST_IDX) begin
                            state_q   <= CHECK;
                            o_tx_data <= checksum_d;
                        end else begin
                            byteIdx_q <= byteIdx_d;
                            o_tx_data <= nextByte;
                        end
                    end
                end
                CHECK: begin
                    if (transfer) begin
                        state_q    <= DONE;
                        o_tx_data  <= '0;
                        o_tx_valid <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    o_done  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: randomized bench for reg_dump_tx. Expected frames are built
// from the register values with plain arithmetic and compared byte by byte.
module tb_reg_dump_tx;

    localparam int BUS_W = 1024;

    logic             clk;
    logic             i_rst_n;
    logic             i_start;
    logic [BUS_W-1:0] i_debug_regs;
    logic             i_tx_ready;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             o_busy;
    logic             o_done;

    int compared;
    int mismatched;

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];

    reg_dump_tx dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_debug_regs (i_debug_regs),
        .i_tx_ready   (i_tx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference frame: header, each register's bytes MSB first, XOR of data.
    task automatic buildFrame(input logic [BUS_W-1:0] regs);
        logic [31:0] word;
        logic [7:0]  b;
        logic [7:0]  chk;
        expQ = {};
        expQ.push_back(8'hA5);
        chk = 8'h00;
        for (int r = 0; r < 32; r++) begin
            word = regs[r*32 +: 32];
            for (int i = 0; i < 4; i++) begin
                b = 8'(word >> (24 - 8 * i));
                expQ.push_back(b);
                chk = chk ^ b;
            end
        end
        expQ.push_back(chk);
    endtask

    // Drive a register image onto the bus and pulse i_start for one cycle.
    task automatic applyStimulus(input logic [BUS_W-1:0] regs);
        @(negedge clk);
        i_debug_regs = regs;
        i_start      = 1'b1;
        buildFrame(regs);
        @(negedge clk);
        i_start      = 1'b0;
    endtask

    // Run one frame after applyStimulus: randomized ready, stability checks,
    // optional mid-frame disturbance or reset abort, then stream comparison.
    task automatic runFrame(input string name, input int readyPct,
                            input bit disturb, input int abortAt);
        int         cycle;
        int         doneCount;
        int         doneCycle;
        int         afterDone;
        bit         prevHold;
        logic [7:0] prevData;
        bit         ready;
        gotQ      = {};
        cycle     = 1;
        doneCount = 0;
        doneCycle = 0;
        afterDone = -1;
        prevHold  = 1'b0;
        prevData  = 8'h00;
        checkOutput({name, "_busy_start"}, 32'(o_busy), 32'd1);
        while (afterDone < 5 && cycle < 3000) begin
            if (prevHold) begin
                checkOutput({name, "_hold_valid"}, 32'(o_tx_valid), 32'd1);
                checkOutput({name, "_hold_data"}, 32'(o_tx_data), 32'(prevData));
            end
            if (o_done) begin
                doneCount++;
                doneCycle = cycle;
                checkOutput({name, "_busy_at_done"}, 32'(o_busy), 32'd0);
            end
            if (afterDone >= 0) afterDone++;
            else if (doneCount > 0) afterDone = 0;
            if (disturb && cycle == 40) begin
                for (int w = 0; w < 32; w++) i_debug_regs[w*32 +: 32] = $urandom;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (abortAt > 0 && gotQ.size() == abortAt + 1 && o_tx_valid) begin
                #2;
                i_rst_n = 1'b0;
                #1;
                checkOutput({name, "_abort_valid"}, 32'(o_tx_valid), 32'd0);
                checkOutput({name, "_abort_busy"}, 32'(o_busy), 32'd0);
                repeat (2) @(negedge clk);
                i_rst_n = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput({name, "_idle_valid"}, 32'(o_tx_valid), 32'd0);
                    checkOutput({name, "_idle_done"}, 32'(o_done), 32'd0);
                end
                return;
            end
            ready      = ($urandom_range(99) < readyPct);
            i_tx_ready = ready;
            if (o_tx_valid && ready) gotQ.push_back(o_tx_data);
            prevHold = o_tx_valid && !ready;
            prevData = o_tx_data;
            @(posedge clk);
            @(negedge clk);
            cycle++;
        end
        i_tx_ready = 1'b0;
        checkOutput({name, "_timeout"}, 32'(cycle < 3000), 32'd1);
        checkOutput({name, "_done_count"}, 32'(doneCount), 32'd1);
        checkOutput({name, "_length"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), 32'(gotQ[i]), 32'(expQ[i]));
        end
        if (readyPct >= 100) checkOutput({name, "_done_cycle"}, 32'(doneCycle), 32'd131);
    endtask

    logic [BUS_W-1:0] basicRegs;
    logic [BUS_W-1:0] orderRegs;
    logic [BUS_W-1:0] randRegs;

    initial begin
        compared     = 0;
        mismatched   = 0;
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_tx_ready   = 1'b0;
        i_debug_regs = '0;

        #12;
        checkOutput("rst_data", 32'(o_tx_data), 32'd0);
        checkOutput("rst_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            i_tx_ready = 1'(c % 2);
            @(negedge clk);
            checkOutput("idle_valid", 32'(o_tx_valid), 32'd0);
        end

        $display("[TB] basic frame");
        basicRegs = '0;
        basicRegs[63:32] = 32'hDEADBEEF;
        applyStimulus(basicRegs);
        runFrame("basic", 100, 1'b0, 0);
        checkOutput("basic_checksum", 32'(gotQ.size() == 130 ? gotQ[129] : 8'hxx), 32'h22);

        $display("[TB] byte ordering");
        for (int k = 0; k < 128; k++) orderRegs[(k/4)*32 + (3 - k%4)*8 +: 8] = 8'(k);
        applyStimulus(orderRegs);
        runFrame("order", 100, 1'b0, 0);
        for (int k = 0; k < 8 && k + 1 < gotQ.size(); k++) begin
            checkOutput($sformatf("order_seq%0d", k), 32'(gotQ[k+1]), 32'(k));
        end

        $display("[TB] backpressure");
        applyStimulus(basicRegs);
        runFrame("bp", 30, 1'b0, 0);

        $display("[TB] snapshot and ignored restart");
        for (int w = 0; w < 32; w++) randRegs[w*32 +: 32] = $urandom;
        applyStimulus(randRegs);
        runFrame("snap", 60, 1'b1, 0);

        $display("[TB] reset mid-frame");
        for (int w = 0; w < 32; w++) randRegs[w*32 +: 32] = $urandom;
        applyStimulus(randRegs);
        runFrame("abort", 100, 1'b0, 50);
        for (int w = 0; w < 32; w++) randRegs[w*32 +: 32] = $urandom;
        applyStimulus(randRegs);
        runFrame("after_abort", 70, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
